nios_lcd_ctrl: RTL and testbench



---
 rtl/nios_lcd_pkg.sv | 32 +++
 rtl/nios_lcd_ctrl_if.sv | 13 +
 rtl/nios_lcd_timer.sv | 27 ++
 rtl/nios_lcd_ctrl.sv | 166 ++++++++++++++++
 tb/tb_nios_lcd_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/nios_lcd_pkg.sv
// Shared types and constants for the HD44780 write controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nios_lcd_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        HOLD  = 3'd3,
        WAIT  = 3'd4
    } lcd_state_e;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_CMD    = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DROP = 1;
    localparam int STAT_IRQ  = 2;

    // Commands whose execution time is far longer than the rest.
    localparam logic [7:0] OP_CLEAR     = 8'h01;
    localparam logic [7:0] OP_HOME      = 8'h02;
    localparam logic [7:0] OP_HOME_ALT  = 8'h03;

    function automatic logic is_long_cmd(input logic [7:0] b);
        return (b == OP_CLEAR) || (b == OP_HOME) || (b == OP_HOME_ALT);
    endfunction

endpackage

// File: rtl/nios_lcd_ctrl_if.sv
// Avalon-MM slave bus bundle between the Nios data master and the LCD controller.
// Latency: zero read latency (readdata is combinational in the slave).
// Backpressure: none; writes to a busy controller are dropped, not stalled.
interface nios_lcd_ctrl_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/nios_lcd_timer.sv
// Loadable down-counter that sequences each phase of an LCD write.
// Latency: value appears the cycle after load; zero_o is combinational on the count.
// Backpressure: none; the count saturates at zero until reloaded.
module nios_lcd_timer #(
    parameter int CW = 17
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [CW-1:0] value_i,
    output logic          zero_o
);
    logic [CW-1:0] cnt_q;

    // Load takes priority; otherwise count down and hold at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= value_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/nios_lcd_ctrl.sv
// HD44780 write sequencer behind an Avalon-MM slave; optional completion irq via LCD_IRQ_EN.
// Latency: pins update the cycle after an accepted write; busy for T_SETUP+T_PULSE+T_HOLD+Tw cycles.
// Backpressure: none; DATA/CMD writes while busy are discarded and flagged in STATUS.drop.
module nios_lcd_ctrl
    import nios_lcd_pkg::*;
#(
    parameter int T_SETUP = 2,
    parameter int T_PULSE = 12,
    parameter int T_HOLD  = 2,
    parameter int T_EXEC  = 2000,
    parameter int T_CLEAR = 82000,
    parameter int CW      = 17
) (
    input  logic                   clk,
    input  logic                   reset,
    nios_lcd_ctrl_if.slave         avs,
    output logic [7:0]             lcd_data,
    output logic                   lcd_rs,
    output logic                   lcd_rw,
    output logic                   lcd_en
`ifdef LCD_IRQ_EN
   ,output logic                   irq
`endif
);
    lcd_state_e    state_q, state_d;
    logic          tmr_load;
    logic [CW-1:0] tmr_value;
    logic          tmr_zero;
    logic          en_q, en_d;
    logic [7:0]    data_q;
    logic          rs_q;
    logic          drop_q;
    logic          busy;
    logic          wr_any, wr_xfer, wr_status, accept, drop_evt, done_evt;
    logic [31:0]   rdata;
    logic          unused_wdata;

    assign wr_any    = avs.chipselect & ~avs.write_n;
    assign wr_xfer   = wr_any & ((avs.address == ADDR_DATA) | (avs.address == ADDR_CMD));
    assign wr_status = wr_any & (avs.address == ADDR_STATUS);
    assign busy      = (state_q != IDLE);
    assign accept    = wr_xfer & ~busy;
    assign drop_evt  = wr_xfer & busy;
    assign done_evt  = (state_q == WAIT) & tmr_zero;
    assign unused_wdata = ^avs.writedata[31:8];

    nios_lcd_timer #(.CW(CW)) u_timer (
        .clk     (clk),
        .rst     (reset),
        .load_i  (tmr_load),
        .value_i (tmr_value),
        .zero_o  (tmr_zero)
    );

    // State register plus the registered enable strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
        end
    end

    // Phase sequencing: each phase reloads the timer with its own length minus one.
    always_comb begin
        state_d   = state_q;
        tmr_load  = 1'b0;
        tmr_value = '0;
        case (state_q)
            IDLE: if (accept) begin
                state_d   = SETUP;
                tmr_load  = 1'b1;
                tmr_value = CW'(T_SETUP - 1);
            end
            SETUP: if (tmr_zero) begin
                state_d   = PULSE;
                tmr_load  = 1'b1;
                tmr_value = CW'(T_PULSE - 1);
            end
            PULSE: if (tmr_zero) begin
                state_d   = HOLD;
                tmr_load  = 1'b1;
                tmr_value = CW'(T_HOLD - 1);
            end
            HOLD: if (tmr_zero) begin
                state_d   = WAIT;
                tmr_load  = 1'b1;
                tmr_value = (~rs_q & is_long_cmd(data_q)) ? CW'(T_CLEAR - 1) : CW'(T_EXEC - 1);
            end
            WAIT: if (tmr_zero) begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Enable is registered from next state so it is glitch-free and exactly T_PULSE long.
        en_d = (state_d == PULSE);
    end

    // Pin latches and the sticky drop flag; a drop in the same cycle as a STATUS write wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= 8'h00;
            rs_q   <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            if (accept) begin
                data_q <= avs.writedata[7:0];
                rs_q   <= (avs.address == ADDR_DATA);
            end
            drop_q <= drop_evt | (drop_q & ~wr_status);
        end
    end

`ifdef LCD_IRQ_EN
    logic irq_pend_q, irq_en_q, irq_q;
    logic wr_ctrl;
    assign wr_ctrl = wr_any & (avs.address == ADDR_CTRL);

    // Completion interrupt: pending set on return to IDLE, cleared by STATUS write, set wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_pend_q <= 1'b0;
            irq_en_q   <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            irq_pend_q <= done_evt | (irq_pend_q & ~wr_status);
            if (wr_ctrl) begin
                irq_en_q <= avs.writedata[0];
            end
            irq_q <= irq_pend_q & irq_en_q;
        end
    end
    assign irq = irq_q;
`else
    logic unused_done;
    assign unused_done = done_evt;
`endif

    // Zero-latency register read mux.
    always_comb begin
        rdata = '0;
        case (avs.address)
            ADDR_STATUS: begin
                rdata[STAT_BUSY] = busy;
                rdata[STAT_DROP] = drop_q;
`ifdef LCD_IRQ_EN
                rdata[STAT_IRQ]  = irq_pend_q;
`endif
            end
            ADDR_CTRL: begin
`ifdef LCD_IRQ_EN
                rdata[0] = irq_en_q;
`endif
            end
            default: ;
        endcase
    end

    assign avs.readdata = rdata;
    assign lcd_data     = data_q;
    assign lcd_rs       = rs_q;
    assign lcd_rw       = 1'b0;
    assign lcd_en       = en_q;
endmodule

// File: tb/tb_nios_lcd_ctrl.sv
// Randomized bench for nios_lcd_ctrl against a timeline model of each LCD write.
// Latency: expectations are derived per cycle from the phase lengths.
// Backpressure: drops are injected mid-transfer and expected in STATUS.
module tb_nios_lcd_ctrl;
    import nios_lcd_pkg::*;

    localparam int T_SETUP = 1;
    localparam int T_PULSE = 3;
    localparam int T_HOLD  = 1;
    localparam int T_EXEC  = 5;
    localparam int T_CLEAR = 10;
`ifdef LCD_IRQ_EN
    localparam bit FEAT = 1'b1;
`else
    localparam bit FEAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] lcd_data;
    logic       lcd_rs, lcd_rw, lcd_en;
`ifdef LCD_IRQ_EN
    logic       irq;
`endif

    nios_lcd_ctrl_if avs();

    nios_lcd_ctrl #(
        .T_SETUP(T_SETUP), .T_PULSE(T_PULSE), .T_HOLD(T_HOLD),
        .T_EXEC(T_EXEC), .T_CLEAR(T_CLEAR), .CW(17)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .avs      (avs),
        .lcd_data (lcd_data),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_en   (lcd_en)
`ifdef LCD_IRQ_EN
       ,.irq      (irq)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference state kept at the register-map level.
    logic [7:0] last_data = 8'h00;
    bit         last_rs   = 1'b0;
    bit         drop_m    = 1'b0;
    bit         pend_m    = 1'b0;
    bit         irq_en_m  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    endtask

    function automatic logic [31:0] status_exp(input bit busy);
        return {29'd0, pend_m & FEAT, drop_m, busy};
    endfunction

    task automatic bus_read(input logic [1:0] a);
        avs.address    = a;
        avs.chipselect = 1'b1;
        avs.write_n    = 1'b1;
        avs.writedata  = '0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        avs.address    = a;
        avs.chipselect = 1'b1;
        avs.write_n    = 1'b0;
        avs.writedata  = d;
    endtask

    // Single register write; ends just after the following falling edge with a STATUS read on the bus.
    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        bus_write(a, d);
        @(posedge clk);
        @(negedge clk);
        bus_read(ADDR_STATUS);
        #1;
    endtask

    task automatic clear_status();
        wr_reg(ADDR_STATUS, $urandom);
        drop_m = 1'b0;
        pend_m = 1'b0;
        chk("status_clr", avs.readdata, status_exp(1'b0));
    endtask

    // One DATA/CMD write checked cycle by cycle; optional colliding write after sample drop_at.
    task automatic xfer(input bit is_cmd, input logic [7:0] b, input int drop_at);
        int  tw, total;
        bit  pend_prev;
        tw    = (is_cmd && b >= 8'h01 && b <= 8'h03) ? T_CLEAR : T_EXEC;
        total = T_SETUP + T_PULSE + T_HOLD + tw;
        pend_prev = pend_m;
        bus_write(is_cmd ? ADDR_CMD : ADDR_DATA, {$urandom_range(0, 16'hffff), 8'h00, b});
        @(posedge clk);
        last_data = b;
        last_rs   = !is_cmd;
        for (int j = 0; j <= total; j++) begin
            @(negedge clk);
            bus_read(ADDR_STATUS);
            if (drop_at >= 0 && j == drop_at + 1) drop_m = 1'b1;
            if (j == total && FEAT) pend_m = 1'b1;
            #1;
            chk("status", avs.readdata, status_exp(j < total));
            chk("en", lcd_en, (j >= T_SETUP && j < T_SETUP + T_PULSE));
            chk("data", lcd_data, last_data);
            chk("rs", lcd_rs, last_rs);
            chk("rw", lcd_rw, 1'b0);
`ifdef LCD_IRQ_EN
            if (j == total) chk("irq_at_done", irq, pend_prev & irq_en_m);
`endif
            if (j == drop_at) bus_write(is_cmd ? ADDR_DATA : ADDR_CMD, {24'd0, ~b});
        end
    endtask

    initial begin
        bit         c;
        logic [7:0] b;
        int         d;
        bus_read(ADDR_STATUS);
        avs.chipselect = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        bus_read(ADDR_STATUS);
        #1;
        chk("rst_status", avs.readdata, 32'h0);
        chk("rst_data", lcd_data, 8'h00);
        chk("rst_rs", lcd_rs, 1'b0);
        chk("rst_en", lcd_en, 1'b0);
        bus_read(ADDR_CTRL);
        #1;
        chk("rst_ctrl", avs.readdata, 32'h0);

        // Directed: data, long command, normal command, collision, back-to-back.
        xfer(1'b0, 8'h41, -1);
        xfer(1'b1, 8'h01, -1);
        xfer(1'b1, 8'h38, -1);
        xfer(1'b1, 8'h38, 2);
        clear_status();
        xfer(1'b0, 8'h42, -1);
        xfer(1'b1, 8'h03, -1);

        // Reset while the enable strobe is high.
        bus_write(ADDR_DATA, 32'h0000_0055);
        @(posedge clk);
        for (int j = 0; j <= T_SETUP; j++) @(negedge clk);
        bus_read(ADDR_STATUS);
        #1;
        chk("pre_rst_en", lcd_en, 1'b1);
        reset = 1'b1;
        #1;
        chk("async_rst_en", lcd_en, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        last_data = 8'h00; last_rs = 1'b0; drop_m = 1'b0; pend_m = 1'b0; irq_en_m = 1'b0;
        #1;
        chk("post_rst_status", avs.readdata, 32'h0);
        chk("post_rst_data", lcd_data, 8'h00);
        chk("post_rst_rs", lcd_rs, 1'b0);

        // Control register: only the feature build keeps irq_en.
        wr_reg(ADDR_CTRL, 32'hffff_ffff);
        bus_read(ADDR_CTRL);
        #1;
        chk("ctrl_rb", avs.readdata, {31'd0, FEAT});
        wr_reg(ADDR_CTRL, 32'h0);

        // Randomized transfers, some with colliding writes.
        for (int k = 0; k < 40; k++) begin
            c = 1'($urandom_range(0, 1));
            b = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
            d = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 5) : -1;
            xfer(c, b, d);
            if ($urandom_range(0, 3) == 0) clear_status();
        end

`ifdef LCD_IRQ_EN
        clear_status();
        wr_reg(ADDR_CTRL, 32'h1);
        irq_en_m = 1'b1;
        xfer(1'b0, 8'h30, -1);
        @(negedge clk);
        #1;
        chk("irq_rise", irq, 1'b1);
        clear_status();
        @(negedge clk);
        #1;
        chk("irq_clr", irq, 1'b0);
        wr_reg(ADDR_CTRL, 32'h0);
        irq_en_m = 1'b0;
        xfer(1'b0, 8'h31, -1);
        @(negedge clk);
        bus_read(ADDR_STATUS);
        #1;
        chk("irq_masked", irq, 1'b0);
        chk("pend_masked", avs.readdata, status_exp(1'b0));
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
